// File: rtl/instr_feeder_if.sv
// Feeder-side bundle: program load port, Start/Done handshake and the DIN/Run issue bus.
// The optional step input exists only when FEEDER_STEP_EN is defined.
interface instr_feeder_if #(
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          start;
    logic          done;
`ifdef FEEDER_STEP_EN
    logic          step;
`endif
    logic [15:0]   din;
    logic          run;
    logic          busy;
    logic          finished;
    logic          error;
    logic [AW-1:0] pc;

    // master: the feeder itself
    modport master (
        input  prog_we, prog_addr, prog_data, start, done,
`ifdef FEEDER_STEP_EN
        input  step,
`endif
        output din, run, busy, finished, error, pc
    );

    // slave: host/processor side
    modport slave (
        output prog_we, prog_addr, prog_data, start, done,
`ifdef FEEDER_STEP_EN
        output step,
`endif
        input  din, run, busy, finished, error, pc
    );
endinterface

// File: rtl/instr_feeder.sv
// Program sequencer: issues mem[PC] with a 1-cycle Run (plus operand for mvi), holds DIN until Done.
// Outputs are combinational from state; Done timeout -> Error. FEEDER_STEP_EN adds single-step gating.
module instr_feeder #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter int          TIMEOUT   = 64,
    parameter logic [2:0]  OPC_IMM   = 3'b001,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_feeder_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_FINISH, S_ERROR, S_STEP
    } state_e;

`ifdef FEEDER_STEP_EN
    localparam state_e S_NEXT = S_STEP;
`else
    localparam state_e S_NEXT = S_ISSUE;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          imm_q, imm_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   mem_q [DEPTH];

    logic [15:0]   cur_word, opnd_word, din_w;
    logic [AW-1:0] pc_p1;
    logic [AW:0]   pc_adv;
    logic          run_w, busy_w, cur_imm, last_addr;

    assign pc_p1     = pc_q + AW'(1);
    assign cur_word  = mem_q[pc_q];
    assign opnd_word = mem_q[pc_p1];
    assign cur_imm   = (cur_word[8:6] == OPC_IMM);
    assign last_addr = (pc_q == AW'(DEPTH - 1));
    // One bit wider than PC so running off the end is detected instead of wrapping
    assign pc_adv    = {1'b0, pc_q} + (imm_q ? (AW+1)'(2) : (AW+1)'(1));
    assign busy_w    = (state_q == S_ISSUE) || (state_q == S_IMM) ||
                       (state_q == S_WAIT)  || (state_q == S_STEP);

    always_ff @(posedge clk_i) begin
        if (bus.prog_we && !busy_w) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            imm_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        tmo_d   = tmo_q;
        din_w   = '0;
        run_w   = 1'b0;
        case (state_q)
            S_IDLE, S_FINISH, S_ERROR: begin
                if (bus.start) begin
                    pc_d    = '0;
                    imm_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cur_word == HALT_WORD) begin
                    state_d = S_FINISH;
                end else begin
                    din_w = cur_word;
                    run_w = 1'b1;
                    imm_d = cur_imm;
                    tmo_d = '0;
                    if (!cur_imm) begin
                        state_d = S_WAIT;
                    end else if (last_addr) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_IMM;
                    end
                end
            end
            S_IMM: begin
                din_w   = opnd_word;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                din_w = imm_q ? opnd_word : cur_word;
                if (bus.done) begin
                    if (pc_adv >= (AW+1)'(DEPTH)) begin
                        state_d = S_FINISH;
                    end else begin
                        pc_d    = pc_adv[AW-1:0];
                        state_d = S_NEXT;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
`ifdef FEEDER_STEP_EN
            S_STEP: begin
                if (bus.step) begin
                    state_d = S_ISSUE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.din      = din_w;
    assign bus.run      = run_w;
    assign bus.busy     = busy_w;
    assign bus.finished = (state_q == S_FINISH);
    assign bus.error    = (state_q == S_ERROR);
    assign bus.pc       = pc_q;
endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: directed scenarios plus random programs, scoreboarded against a program-walk model.
module tb_instr_feeder;
    localparam int          DEPTH   = 16;
    localparam int          AW      = 4;
    localparam int          TIMEOUT = 64;
    localparam logic [15:0] HALT    = 16'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_feeder_if #(.AW(AW)) ifc ();

    instr_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    typedef struct {
        logic [15:0] word;
        logic [15:0] hold;
    } issue_t;

    typedef struct {
        bit fin;
        bit err;
        int pc;
        int tmo;   // cycles from Run to Busy falling, -1 = don't care
    } outcome_t;

    issue_t      exp_q[$];
    outcome_t    out_q[$];
    logic [15:0] mm [DEPTH];
    int          vectors     = 0;
    int          miscompares = 0;
    bit          resp_en     = 1'b0;
    int          resp_lo     = 2;
    int          resp_hi     = 6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk the program by its rules, queueing each issue and the final outcome
    function automatic void model(input bit resp);
        int  pc;
        bit  imm;
        pc = 0;
        while (1) begin
            if (mm[pc] == HALT) begin
                out_q.push_back('{1'b1, 1'b0, pc, -1});
                return;
            end
            imm = (mm[pc][8:6] == 3'b001);
            if (imm && pc == DEPTH - 1) begin
                exp_q.push_back('{mm[pc], mm[pc]});
                out_q.push_back('{1'b0, 1'b1, pc, -1});
                return;
            end
            exp_q.push_back('{mm[pc], imm ? mm[pc+1] : mm[pc]});
            if (!resp) begin
                out_q.push_back('{1'b0, 1'b1, pc, TIMEOUT + 1 + int'(imm)});
                return;
            end
            if (pc + (imm ? 2 : 1) >= DEPTH) begin
                out_q.push_back('{1'b1, 1'b0, pc, -1});
                return;
            end
            pc = pc + (imm ? 2 : 1);
        end
    endfunction

    // Processor stand-in: Done a few cycles after each Run
    initial begin
        int d;
        ifc.done = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.run && resp_en) begin
                d = $urandom_range(resp_hi, resp_lo);
                repeat (d) @(posedge clk);
                #1 ifc.done = 1'b1;
                @(posedge clk);
                #1 ifc.done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit          busy_prev = 1'b0;
        bit          inflight  = 1'b0;
        logic [15:0] hold      = '0;
        int          cyc       = 0;
        issue_t      e;
        outcome_t    o;
        forever begin
            @(negedge clk);
            cyc++;
            if (ifc.run) begin
                cyc = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_run", 32'(ifc.din), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_din", 32'(ifc.din), 32'(e.word));
                    hold     = e.hold;
                    inflight = 1'b1;
                end
            end else if (inflight && ifc.busy) begin
                check("hold_din", 32'(ifc.din), 32'(hold));
            end
            if (inflight && ifc.done) inflight = 1'b0;
            if (busy_prev && !ifc.busy) begin
                inflight = 1'b0;
                if (out_q.size() == 0) begin
                    check("unexpected_end", 32'(ifc.busy), 32'd1);
                end else begin
                    o = out_q.pop_front();
                    check("end_finished", 32'(ifc.finished), 32'(o.fin));
                    check("end_error", 32'(ifc.error), 32'(o.err));
                    check("end_pc", 32'(ifc.pc), 32'(o.pc));
                    check("end_din", 32'(ifc.din), 32'd0);
                    check("end_run", 32'(ifc.run), 32'd0);
                    check("end_issues_left", 32'(exp_q.size()), 32'd0);
                    if (o.tmo >= 0) check("timeout_cycles", 32'(cyc), 32'(o.tmo));
                    exp_q.delete();
                end
            end
            busy_prev = ifc.busy;
        end
    end

    task automatic load_mem();
        for (int i = 0; i < DEPTH; i++) begin
            ifc.prog_we   = 1'b1;
            ifc.prog_addr = AW'(i);
            ifc.prog_data = mm[i];
            @(posedge clk);
            #1;
        end
        ifc.prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        @(posedge clk);
        #1 ifc.start = 1'b0;
    endtask

    task automatic wait_outcome();
        int n = 0;
        while (out_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (out_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL outcome_wait: got %0d pending outcomes expected 0", out_q.size());
            out_q.delete();
            exp_q.delete();
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic run_prog(input bit do_load, input bit resp, input bit inject_we);
        if (do_load) load_mem();
        resp_en = resp;
        model(resp);
        pulse_start();
        if (inject_we) begin
            ifc.prog_we   = 1'b1;
            ifc.prog_addr = '0;
            ifc.prog_data = 16'h0010;
            @(posedge clk);
            #1 ifc.prog_we = 1'b0;
        end
        wait_outcome();
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        int          k;
        k = $urandom_range(15, 0);
        w = 16'($urandom);
        if (k == 0) return HALT;
        if (k <= 4) w[8:6] = 3'b001;
        if (w == HALT) w = 16'h0008;
        return w;
    endfunction

    initial begin
        ifc.prog_we   = 1'b0;
        ifc.prog_addr = '0;
        ifc.prog_data = '0;
        ifc.start     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_din", 32'(ifc.din), 32'd0);
        check("rst_run", 32'(ifc.run), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_finished", 32'(ifc.finished), 32'd0);
        check("rst_error", 32'(ifc.error), 32'd0);
        check("rst_pc", 32'(ifc.pc), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // mv then halt, Done 3 cycles after Run
        resp_lo = 3; resp_hi = 3;
        for (int i = 0; i < DEPTH; i++) mm[i] = rand_word();
        mm[0] = 16'h0008; mm[1] = HALT;
        run_prog(1'b1, 1'b1, 1'b0);

        // mvi with operand, then halt
        mm[0] = 16'h0042; mm[1] = 16'h0005; mm[2] = HALT;
        run_prog(1'b1, 1'b1, 1'b0);

        // Done never comes
        mm[0] = 16'h0008; mm[1] = HALT;
        run_prog(1'b1, 1'b0, 1'b0);

        // Reset during WAIT, then rerun with memory intact
        resp_en = 1'b0;
        exp_q.push_back('{16'h0008, 16'h0008});
        out_q.push_back('{1'b0, 1'b0, 0, -1});
        pulse_start();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_outcome();
        run_prog(1'b0, 1'b1, 1'b0);

        // Write while busy is dropped; rerun still sees the old word
        run_prog(1'b0, 1'b1, 1'b1);
        run_prog(1'b0, 1'b1, 1'b0);

        // mvi in the last word
        for (int i = 0; i < DEPTH - 1; i++) mm[i] = 16'h0008;
        mm[DEPTH-1] = 16'h0042;
        run_prog(1'b1, 1'b1, 1'b0);

        // mvi in the second-to-last word runs off the end cleanly
        mm[DEPTH-2] = 16'h0042; mm[DEPTH-1] = 16'h1234;
        run_prog(1'b1, 1'b1, 1'b0);

        resp_lo = 2; resp_hi = 6;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < DEPTH; i++) mm[i] = rand_word();
            run_prog(1'b1, ($urandom_range(9, 0) != 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
